// File: rtl/amplifier_bank_ramped.sv
// Ramped per-channel gain stage: one signed sample is scaled by NUMBER_OF_FILTERS
// independently ramping gains, rounded/saturated, and delivered through a
// two-stage valid/ready pipeline with sticky per-channel saturation flags.
module amplifier_bank_ramped #(
  parameter int NUMBER_OF_FILTERS = 8,
  parameter int GAIN_BITS         = 8,
  parameter int GAIN_FRAC_BITS    = 4,
  parameter int FILTER_IN_BITS    = 16,
  parameter int RAMP_STEP         = 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        en,
  input  logic                                        round_en,
  input  logic                                        gain_load,
  input  logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0]      gains_target,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [FILTER_IN_BITS-1:0]                   filter_in,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [NUMBER_OF_FILTERS*FILTER_IN_BITS-1:0] amplified_filter_ins,
  output logic                                        ramping,
  input  logic                                        sat_clear,
  output logic [NUMBER_OF_FILTERS-1:0]                sat_flags
);

  localparam int N   = NUMBER_OF_FILTERS;
  localparam int GB  = GAIN_BITS;
  localparam int FIB = FILTER_IN_BITS;
  localparam int PW  = FIB + GB;

  localparam logic signed [GB-1:0] UNITY  = GB'(1 << GAIN_FRAC_BITS);
  localparam logic signed [GB:0]   STEP_W = (GB+1)'(RAMP_STEP);
  localparam logic signed [PW:0]   HALF   = (PW+1)'((1 << GAIN_FRAC_BITS) >> 1);
  localparam logic signed [PW:0]   MAXV   = (PW+1)'((1 << (FIB-1)) - 1);
  localparam logic signed [PW:0]   MINV   = ~MAXV;

  // Move cur one ramp step toward tgt, landing exactly on tgt when close.
  function automatic logic signed [GB-1:0] ramp_step(input logic signed [GB-1:0] cur,
                                                      input logic signed [GB-1:0] tgt);
    logic signed [GB:0] c_w, t_w, diff, nxt;
    c_w  = {cur[GB-1], cur};
    t_w  = {tgt[GB-1], tgt};
    diff = t_w - c_w;
    if (diff > STEP_W)       nxt = c_w + STEP_W;
    else if (diff < -STEP_W) nxt = c_w - STEP_W;
    else                     nxt = t_w;
    ramp_step = nxt[GB-1:0];
  endfunction

  // Full-precision product, optional half-LSB rounding, then drop the fraction.
  function automatic logic signed [PW:0] round_shift(input logic signed [FIB-1:0] x,
                                                      input logic signed [GB-1:0]  g,
                                                      input logic                  rnd);
    logic signed [PW-1:0] prod;
    logic signed [PW:0]   sum;
    prod = PW'(x) * PW'(g);
    sum  = {prod[PW-1], prod};
    if (rnd) sum = sum + HALF;
    round_shift = sum >>> GAIN_FRAC_BITS;
  endfunction

  // Clamp to the sample range; the MSB of the result reports clipping.
  function automatic logic [FIB:0] saturate(input logic signed [PW:0] v);
    if (v > MAXV)      saturate = {1'b1, MAXV[FIB-1:0]};
    else if (v < MINV) saturate = {1'b1, MINV[FIB-1:0]};
    else               saturate = {1'b0, v[FIB-1:0]};
  endfunction

  logic                  advance, accept;
  logic                  vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic signed [GB-1:0]  cur_gain_q [N];
  logic signed [GB-1:0]  cur_gain_d [N];
  logic signed [GB-1:0]  tgt_gain_q [N];
  logic signed [GB-1:0]  tgt_gain_d [N];
  logic signed [FIB-1:0] samp_p1_q, samp_p1_d;
  logic                  en_p1_q, en_p1_d, rnd_p1_q, rnd_p1_d;
  logic signed [GB-1:0]  gain_p1_q [N];
  logic signed [GB-1:0]  gain_p1_d [N];
  logic signed [FIB-1:0] calc_res [N];
  logic                  calc_sat [N];
  logic signed [FIB-1:0] res_p2_q [N];
  logic signed [FIB-1:0] res_p2_d [N];
  logic [N-1:0]          sat_flags_q, sat_flags_d;

  // Stage 1 -> stage 2 arithmetic: scale, round and clip every channel (bypass passes through).
  always_comb begin
    for (int k = 0; k < N; k++) begin
      calc_sat[k] = 1'b0;
      calc_res[k] = samp_p1_q;
      if (en_p1_q) {calc_sat[k], calc_res[k]} = saturate(round_shift(samp_p1_q, gain_p1_q[k], rnd_p1_q));
    end
  end

  // Handshake, gain ramp, pipeline next-state and sticky flag logic.
  always_comb begin
    advance     = !vld_p2_q || out_ready;
    accept      = in_valid && advance;
    vld_p1_d    = vld_p1_q;
    vld_p2_d    = vld_p2_q;
    samp_p1_d   = samp_p1_q;
    en_p1_d     = en_p1_q;
    rnd_p1_d    = rnd_p1_q;
    sat_flags_d = sat_clear ? '0 : sat_flags_q;
    if (advance) begin
      vld_p1_d = accept;
      vld_p2_d = vld_p1_q;
    end
    if (accept) begin
      samp_p1_d = filter_in;
      en_p1_d   = en;
      rnd_p1_d  = round_en;
    end
    for (int k = 0; k < N; k++) begin
      gain_p1_d[k]  = accept ? cur_gain_q[k] : gain_p1_q[k];
      cur_gain_d[k] = (accept && en) ? ramp_step(cur_gain_q[k], tgt_gain_q[k]) : cur_gain_q[k];
      tgt_gain_d[k] = gain_load ? gains_target[k*GB +: GB] : tgt_gain_q[k];
      res_p2_d[k]   = res_p2_q[k];
      if (advance && vld_p1_q) begin
        res_p2_d[k] = calc_res[k];
        if (calc_sat[k]) sat_flags_d[k] = 1'b1;
      end
    end
  end

  // Control, gain and output registers; reset returns to unity gain and an empty pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      sat_flags_q <= '0;
      for (int k = 0; k < N; k++) begin
        cur_gain_q[k] <= UNITY;
        tgt_gain_q[k] <= UNITY;
        res_p2_q[k]   <= '0;
      end
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      sat_flags_q <= sat_flags_d;
      for (int k = 0; k < N; k++) begin
        cur_gain_q[k] <= cur_gain_d[k];
        tgt_gain_q[k] <= tgt_gain_d[k];
        res_p2_q[k]   <= res_p2_d[k];
      end
    end
  end

  // Stage 1 data registers; qualified by vld_p1_q so they need no reset.
  always_ff @(posedge clk) begin
    samp_p1_q <= samp_p1_d;
    en_p1_q   <= en_p1_d;
    rnd_p1_q  <= rnd_p1_d;
    for (int k = 0; k < N; k++) gain_p1_q[k] <= gain_p1_d[k];
  end

  // Any channel still moving toward its target.
  always_comb begin
    ramping = 1'b0;
    for (int k = 0; k < N; k++) if (cur_gain_q[k] != tgt_gain_q[k]) ramping = 1'b1;
  end

  for (genvar k = 0; k < N; k++) begin : g_out
    assign amplified_filter_ins[k*FIB +: FIB] = res_p2_q[k];
  end

  assign in_ready  = advance;
  assign out_valid = vld_p2_q;
  assign sat_flags = sat_flags_q;

endmodule

// File: tb/tb_amplifier_bank_ramped.sv
// Bench for amplifier_bank_ramped: directed corner sequences, a vector table
// for rounding/clipping, and randomized traffic against a behavioural model.
module tb_amplifier_bank_ramped;
  localparam int N   = 8;
  localparam int GB  = 8;
  localparam int GF  = 4;
  localparam int FIB = 16;
  localparam int RS  = 1;

  logic clk = 1'b0;
  logic rst_n, en, round_en, gain_load, in_valid, in_ready, out_valid, out_ready;
  logic ramping, sat_clear;
  logic [N*GB-1:0]  gains_target;
  logic [FIB-1:0]   filter_in;
  logic [N*FIB-1:0] amplified_filter_ins;
  logic [N-1:0]     sat_flags;

  amplifier_bank_ramped #(
    .NUMBER_OF_FILTERS(N), .GAIN_BITS(GB), .GAIN_FRAC_BITS(GF),
    .FILTER_IN_BITS(FIB), .RAMP_STEP(RS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .round_en(round_en), .gain_load(gain_load),
    .gains_target(gains_target), .in_valid(in_valid), .in_ready(in_ready),
    .filter_in(filter_in), .out_valid(out_valid), .out_ready(out_ready),
    .amplified_filter_ins(amplified_filter_ins), .ramping(ramping),
    .sat_clear(sat_clear), .sat_flags(sat_flags)
  );

  always #5 clk = ~clk;

  typedef struct { int v[N]; logic [N-1:0] sat; } exp_t;
  typedef struct { int x; bit rnd; bit en; int exp0; } vec_t;

  int           n_chk = 0, n_pass = 0;
  int           m_cur[N], m_tgt[N];
  logic [N-1:0] m_sticky;
  exp_t         q[$];
  int           last_out[N];
  int           out_hist0[$];
  bit           last_acc;
  int           out_cnt = 0;
  bit           chk_sat;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int get_out(input int k);
    logic signed [FIB-1:0] v;
    v = amplified_filter_ins[k*FIB +: FIB];
    return int'(v);
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Gain is a fixed-point number with GF fraction bits; floor or round-half-up.
  function automatic int amp(input int x, input int g, input bit rnd);
    int p;
    p = x * g;
    if (rnd) p = p + (1 << (GF - 1));
    return p >>> GF;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin m_cur[k] = 16; m_tgt[k] = 16; end
    m_sticky = '0;
    q.delete();
  endtask

  // One clock: observe at the falling edge, advance the model for the coming rising edge.
  task automatic tick();
    exp_t e;
    int x, r, s;
    bit er;
    logic signed [GB-1:0] gt;
    @(negedge clk);
    er = 0;
    for (int k = 0; k < N; k++) if (m_cur[k] != m_tgt[k]) er = 1;
    chk("ramping", int'(ramping), int'(er));
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        for (int k = 0; k < N; k++) chk($sformatf("out_ch%0d", k), get_out(k), q[0].v[k]);
        if (chk_sat) chk("sat_flags", int'(sat_flags), int'(m_sticky | q[0].sat));
        if (out_ready) begin
          m_sticky = m_sticky | q[0].sat;
          for (int k = 0; k < N; k++) last_out[k] = get_out(k);
          out_hist0.push_back(get_out(0));
          out_cnt++;
          void'(q.pop_front());
        end
      end
    end else if (chk_sat) chk("sat_flags", int'(sat_flags), int'(m_sticky));
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      x = int'($signed(filter_in));
      e.sat = '0;
      for (int k = 0; k < N; k++) begin
        if (en) begin
          r = amp(x, m_cur[k], round_en);
          s = sat16(r);
          e.v[k] = s;
          e.sat[k] = (s != r);
          if (m_cur[k] < m_tgt[k]) m_cur[k] = (m_cur[k] + RS > m_tgt[k]) ? m_tgt[k] : m_cur[k] + RS;
          else if (m_cur[k] > m_tgt[k]) m_cur[k] = (m_cur[k] - RS < m_tgt[k]) ? m_tgt[k] : m_cur[k] - RS;
        end else e.v[k] = x;
      end
      q.push_back(e);
    end
    if (gain_load)
      for (int k = 0; k < N; k++) begin gt = gains_target[k*GB +: GB]; m_tgt[k] = int'(gt); end
    if (sat_clear) m_sticky = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x);
    int b;
    b = 0;
    in_valid = 1'b1;
    filter_in = FIB'(x);
    do begin tick(); b++; end while (!last_acc && b < 50);
    if (!last_acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && b < 50) begin tick(); b++; end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic load_gains(input int g0, input int g1, input int g2);
    for (int k = 0; k < N; k++) gains_target[k*GB +: GB] = GB'(16);
    gains_target[0*GB +: GB] = GB'(g0);
    gains_target[1*GB +: GB] = GB'(g1);
    gains_target[2*GB +: GB] = GB'(g2);
    in_valid = 1'b0;
    gain_load = 1'b1;
    tick();
    gain_load = 1'b0;
  endtask

  task automatic ramp_settle();
    int b;
    b = 0;
    while (ramping && b < 300) begin send(0); b++; end
    chk("ramp_settle", int'(ramping), 0);
    drain();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_outputs_zero"}, int'(amplified_filter_ins == '0), 1);
    chk({tag, "_ramping"}, int'(ramping), 0);
    chk({tag, "_sat_flags"}, int'(sat_flags), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; gain_load = 1'b0; sat_clear = 1'b0; out_ready = 1'b1;
    en = 1'b1; round_en = 1'b0; filter_in = '0;
    for (int k = 0; k < N; k++) gains_target[k*GB +: GB] = GB'(16);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[10];
    int exp2[6];
    int idx, c, start;
    tbl[0] = '{3, 1'b0, 1'b1, 4};
    tbl[1] = '{3, 1'b1, 1'b1, 5};
    tbl[2] = '{-3, 1'b0, 1'b1, -5};
    tbl[3] = '{-3, 1'b1, 1'b1, -4};
    tbl[4] = '{-1, 1'b0, 1'b1, -2};
    tbl[5] = '{-1, 1'b1, 1'b1, -1};
    tbl[6] = '{100, 1'b1, 1'b1, 150};
    tbl[7] = '{32767, 1'b1, 1'b1, 32767};
    tbl[8] = '{-32768, 1'b0, 1'b1, -32768};
    tbl[9] = '{-12345, 1'b0, 1'b0, -12345};
    exp2 = '{160, 170, 180, 190, 200, 200};
    chk_sat = 1'b1;

    do_reset();

    // Unity gain, two-register latency.
    send(1000);
    chk("lat_after_accept", int'(out_valid), 0);
    tick();
    chk("lat_two_cycles", int'(out_valid), 1);
    chk("unity_pos", get_out(0), 1000);
    send(-1000);
    drain();
    chk("unity_neg_ch0", last_out[0], -1000);
    chk("unity_neg_ch7", last_out[7], -1000);
    chk("unity_ramping", int'(ramping), 0);

    // Ramp ch0 from 16 to 20.
    load_gains(20, 16, 16);
    out_hist0.delete();
    for (int i = 0; i < 6; i++) begin
      send(160);
      chk($sformatf("ramp_flag_after_%0d", i + 1), int'(ramping), (i < 3) ? 1 : 0);
    end
    drain();
    chk("ramp_hist_len", out_hist0.size(), 6);
    for (int i = 0; i < 6 && i < out_hist0.size(); i++)
      chk($sformatf("ramp_out_%0d", i), out_hist0[i], exp2[i]);
    chk("ramp_other_ch", last_out[1], 160);

    // Saturation on ch1 at gain 4.0 and sticky flag behaviour.
    load_gains(20, 64, 16);
    ramp_settle();
    send(10000);
    drain();
    chk("sat_pos", last_out[1], 32767);
    chk("sat_flag1", int'(sat_flags[1]), 1);
    chk("sat_flag0", int'(sat_flags[0]), 0);
    send(-10000);
    drain();
    chk("sat_neg", last_out[1], -32768);
    chk_sat = 1'b0;
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    chk("sat_cleared", int'(sat_flags), 0);
    in_valid = 1'b1;
    filter_in = FIB'(10000);
    tick();
    in_valid = 1'b0;
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    chk("sat_set_wins", int'(sat_flags[1]), 1);
    drain();

    // Rounding / clipping table on ch0 at gain 1.5.
    load_gains(24, 16, 16);
    ramp_settle();
    for (int i = 0; i < 10; i++) begin
      round_en = tbl[i].rnd;
      en = tbl[i].en;
      send(tbl[i].x);
      drain();
      chk($sformatf("tbl_%0d", i), last_out[0], tbl[i].exp0);
    end
    en = 1'b1;
    round_en = 1'b0;

    // Burst of 20 with a 5-cycle downstream stall while ch0 ramps.
    load_gains(30, 16, 16);
    idx = 0; c = 0; start = out_cnt;
    while ((idx < 20 || q.size() != 0) && c < 200) begin
      in_valid = (idx < 20);
      filter_in = FIB'(idx * 1500 - 14000);
      out_ready = !(c >= 6 && c < 11);
      if (c == 10) begin #1; chk("stall_in_ready", int'(in_ready), 0); end
      tick();
      if (last_acc) idx++;
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", out_cnt - start, 20);

    // Asynchronous reset mid-ramp while an output is held.
    load_gains(16, 16, 100);
    in_valid = 1'b1;
    out_ready = 1'b0;
    filter_in = FIB'(500);
    repeat (4) tick();
    chk("pre_rst_out_valid", int'(out_valid), 1);
    chk("pre_rst_ramping", int'(ramping), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("async_rst");
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_sat = 1'b1;
    send(1000);
    drain();
    chk("post_rst_ch2", last_out[2], 1000);
    chk("post_rst_ch0", last_out[0], 1000);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      round_en  = 1'($urandom_range(0, 1));
      filter_in = FIB'($urandom);
      gain_load = ($urandom_range(0, 29) == 0);
      if (gain_load)
        for (int k = 0; k < N; k++) gains_target[k*GB +: GB] = GB'($urandom_range(0, 255));
      tick();
    end
    gain_load = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
